// File: rtl/video_pattern_gen_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern source:
// FSM states, pattern codes and the colour-bar palette in {R,B,G} order.
package video_pattern_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_SOLID   = 2'd3;

    // The block design's video_in_stream carries blue in the middle byte.
    function automatic logic [PIX_W-1:0] pack_rbg(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        return {r, b, g};
    endfunction

    localparam logic [PIX_W-1:0] BAR_WHITE   = pack_rbg(8'hFF, 8'hFF, 8'hFF);
    localparam logic [PIX_W-1:0] BAR_YELLOW  = pack_rbg(8'hFF, 8'hFF, 8'h00);
    localparam logic [PIX_W-1:0] BAR_CYAN    = pack_rbg(8'h00, 8'hFF, 8'hFF);
    localparam logic [PIX_W-1:0] BAR_GREEN   = pack_rbg(8'h00, 8'hFF, 8'h00);
    localparam logic [PIX_W-1:0] BAR_MAGENTA = pack_rbg(8'hFF, 8'h00, 8'hFF);
    localparam logic [PIX_W-1:0] BAR_RED     = pack_rbg(8'hFF, 8'h00, 8'h00);
    localparam logic [PIX_W-1:0] BAR_BLUE    = pack_rbg(8'h00, 8'h00, 8'hFF);
    localparam logic [PIX_W-1:0] BAR_BLACK   = pack_rbg(8'h00, 8'h00, 8'h00);

endpackage

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern source and the video_in_stream slave.
interface video_pattern_gen_if;
    import video_pattern_pkg::*;

    logic [PIX_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tuser;
    logic             tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast,
                    input  tready);
    modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast,
                    output tready);

endinterface

// File: rtl/video_pattern_gen_pixel.sv
// Combinational pixel lookup: (x, y, pattern, ramp offset) -> {R,B,G} pixel.
module video_pattern_pixel
    import video_pattern_pkg::*;
#(
    parameter int              H_ACTIVE  = 640,
    parameter int              XW        = 11,
    parameter int              YW        = 10,
    parameter logic [PIX_W-1:0] SOLID_RGB = 24'h808080
) (
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [1:0]       pattern,
    input  logic [7:0]       ramp_ofs,
    output logic [PIX_W-1:0] pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;
    logic [7:0] ramp;
    logic       x_b3;
    logic       y_b3;

    // Masking instead of slicing keeps short y counters (V_ACTIVE < 8) legal.
    always_comb begin
        bar  = 3'(x / XW'(BAR_W));
        ramp = 8'(x) + ramp_ofs;
        x_b3 = |(x & XW'(8));
        y_b3 = |(y & YW'(8));
    end

    always_comb begin
        pixel = '0;
        case (pattern)
            PAT_BARS: begin
                case (bar)
                    3'd0:    pixel = BAR_WHITE;
                    3'd1:    pixel = BAR_YELLOW;
                    3'd2:    pixel = BAR_CYAN;
                    3'd3:    pixel = BAR_GREEN;
                    3'd4:    pixel = BAR_MAGENTA;
                    3'd5:    pixel = BAR_RED;
                    3'd6:    pixel = BAR_BLUE;
                    default: pixel = BAR_BLACK;
                endcase
            end
            PAT_RAMP:    pixel = pack_rbg(ramp, ramp, ramp);
            PAT_CHECKER: pixel = (x_b3 ^ y_b3) ? BAR_WHITE : BAR_BLACK;
            default:     pixel = SOLID_RGB;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern frame source (SOF on tuser, EOL on tlast).
// Optional VIDEO_PATTERN_GEN_FRAME_CNT_EN adds frame_cnt and a moving ramp.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int               H_ACTIVE  = 640,
    parameter int               V_ACTIVE  = 480,
    parameter int               H_BLANK   = 16,
    parameter int               V_BLANK   = 64,
    parameter logic [PIX_W-1:0] SOLID_RGB = 24'h808080
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    video_pattern_gen_if.master        video_in_stream
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]                frame_cnt
`endif
);

    localparam int XW        = $clog2(H_ACTIVE) + 1;
    localparam int YW        = $clog2(V_ACTIVE) + 1;
    localparam int BLANK_TOT = H_BLANK + V_BLANK;
    localparam int BW        = $clog2(BLANK_TOT + 1) + 1;

    state_t           state, state_nxt;
    logic [XW-1:0]    x, x_nxt;
    logic [YW-1:0]    y, y_nxt;
    logic [BW-1:0]    blank_cnt, blank_nxt;
    logic [1:0]       pat, pat_nxt;
    logic             hs, last_px, last_line, frame_hs, frame_done;
    logic             tvalid_nxt, tuser_nxt, tlast_nxt;
    logic [PIX_W-1:0] pix_nxt, tdata_nxt;
    logic [7:0]       ramp_ofs;

    assign hs        = video_in_stream.tvalid && video_in_stream.tready;
    assign last_px   = (x == XW'(H_ACTIVE - 1));
    assign last_line = (y == YW'(V_ACTIVE - 1));
    assign frame_hs  = hs && last_px && last_line;

`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_nxt;

    assign frame_cnt_nxt = frame_cnt + 16'(frame_hs);
    assign ramp_ofs      = frame_cnt_nxt[7:0];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) frame_cnt <= '0;
        else           frame_cnt <= frame_cnt_nxt;
    end
`else
    assign ramp_ofs = 8'd0;
`endif

    // State and counter register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            blank_cnt <= '0;
            pat       <= PAT_BARS;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            blank_cnt <= blank_nxt;
            pat       <= pat_nxt;
        end
    end

    // Next state; enable and pattern_sel are only looked at on frame boundaries
    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        blank_nxt  = blank_cnt;
        pat_nxt    = pat;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    pat_nxt   = pattern_sel;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (hs) begin
                    if (last_px) begin
                        x_nxt     = '0;
                        y_nxt     = y + 1'b1;
                        blank_nxt = '0;
                        if (last_line) begin
                            if (BLANK_TOT == 0) frame_done = 1'b1;
                            else                state_nxt  = VBLANK;
                        end else if (H_BLANK != 0) begin
                            state_nxt = HBLANK;
                        end
                    end else begin
                        x_nxt = x + 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (blank_cnt == BW'(H_BLANK - 1)) begin
                    blank_nxt = '0;
                    state_nxt = ACTIVE;
                end else begin
                    blank_nxt = blank_cnt + 1'b1;
                end
            end
            VBLANK: begin
                if (blank_cnt == BW'(BLANK_TOT - 1)) begin
                    blank_nxt  = '0;
                    frame_done = 1'b1;
                end else begin
                    blank_nxt = blank_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_done) begin
            x_nxt = '0;
            y_nxt = '0;
            if (enable) begin
                pat_nxt   = pattern_sel;
                state_nxt = ACTIVE;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    video_pattern_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .XW        (XW),
        .YW        (YW),
        .SOLID_RGB (SOLID_RGB)
    ) u_pixel (
        .x        (x_nxt),
        .y        (y_nxt),
        .pattern  (pat_nxt),
        .ramp_ofs (ramp_ofs),
        .pixel    (pix_nxt)
    );

    // Outputs derive from next-cycle counters so the registered beat lines up
    // with the counters and a stalled beat recomputes to the same value.
    always_comb begin
        tvalid_nxt = (state_nxt == ACTIVE);
        tuser_nxt  = tvalid_nxt && (x_nxt == '0) && (y_nxt == '0);
        tlast_nxt  = tvalid_nxt && (x_nxt == XW'(H_ACTIVE - 1));
        tdata_nxt  = tvalid_nxt ? pix_nxt : '0;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            video_in_stream.tvalid <= 1'b0;
            video_in_stream.tuser  <= 1'b0;
            video_in_stream.tlast  <= 1'b0;
            video_in_stream.tdata  <= '0;
        end else begin
            video_in_stream.tvalid <= tvalid_nxt;
            video_in_stream.tuser  <= tuser_nxt;
            video_in_stream.tlast  <= tlast_nxt;
            video_in_stream.tdata  <= tdata_nxt;
        end
    end

endmodule
